// File: rtl/mem_stream_tx_pkg.sv
// Shared definitions for the memory-to-UART streamer: FSM state encoding and
// the legal read-latency range.
package mem_stream_tx_pkg;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_WAIT_DATA = 4'd2,
      S_WAIT_RDY  = 4'd3,
      S_LAUNCH    = 4'd4,
      S_WAIT_ACK  = 4'd5,
      S_WAIT_TX   = 4'd6,
      S_GAP       = 4'd7,
      S_DONE      = 4'd8
   } state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;

   // Out-of-range latencies are pinned to the nearest legal value so the
   // 2-bit latency counter can never run past its terminal count.
   function automatic int clamp_rd_lat(input int lat);
      if (lat < RD_LAT_MIN) return RD_LAT_MIN;
      if (lat > RD_LAT_MAX) return RD_LAT_MAX;
      return lat;
   endfunction

endpackage

// File: rtl/mem_stream_tx_edge_rise.sv
// Registered rising-edge detector: rise is high while d is 1 and was 0 on the
// previous clock.
module mem_stream_tx_edge_rise (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) d_q <= 1'b0;
      else     d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/mem_stream_tx.sv
// Streams cfg_len bytes from a synchronous RAM starting at cfg_base to a UART
// transmitter, with read latency, inter-byte gap, loop mode and abort.
module mem_stream_tx
   import mem_stream_tx_pkg::*;
#(
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 8,
   parameter int RD_LAT  = 1,
   parameter int GAP_CYC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W:0]   cfg_len,
   input  logic              cfg_loop,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_start,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   sent_cnt
);

   localparam int LAT   = clamp_rd_lat(RD_LAT);
   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   state_t            state, state_nxt;
   logic              start_rise;
   logic [ADDR_W-1:0] base_q, offset;
   logic [ADDR_W:0]   len_q, sent_inc;
   logic              loop_q, abort_pend;
   logic [1:0]        lat_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              launch, capture, byte_done, wrap;

   mem_stream_tx_edge_rise u_start_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (start),
      .rise (start_rise)
   );

   assign sent_inc = sent_cnt + (ADDR_W+1)'(1);

   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      capture   = 1'b0;
      byte_done = 1'b0;
      wrap      = 1'b0;
      case (state)
         S_IDLE: if (start_rise && !abort) begin
            launch    = 1'b1;
            state_nxt = (cfg_len == '0) ? S_DONE : S_FETCH;
         end
         S_FETCH:     state_nxt = abort ? S_IDLE : S_WAIT_DATA;
         S_WAIT_DATA: if (abort) state_nxt = S_IDLE;
                      else if (lat_cnt == 2'(LAT-1)) begin
                         capture   = 1'b1;
                         state_nxt = S_WAIT_RDY;
                      end
         S_WAIT_RDY:  if (abort) state_nxt = S_IDLE;
                      else if (tx_ready) state_nxt = S_LAUNCH;
         S_LAUNCH:    state_nxt = abort ? S_IDLE : S_WAIT_ACK;
         S_WAIT_ACK:  if (!tx_ready) state_nxt = S_WAIT_TX;
         // An abort seen here or in WAIT_ACK still lets the current byte drain.
         S_WAIT_TX: if (tx_ready) begin
            byte_done = 1'b1;
            if (abort || abort_pend) state_nxt = S_IDLE;
            else if (GAP_CYC != 0) state_nxt = S_GAP;
            else if (sent_inc == len_q) begin
               wrap      = loop_q;
               state_nxt = loop_q ? S_FETCH : S_DONE;
            end else state_nxt = S_FETCH;
         end
         S_GAP: if (abort) state_nxt = S_IDLE;
            else if (gap_cnt == GAP_W'(GAP_CYC-1)) begin
               if (sent_cnt == len_q) begin
                  wrap      = loop_q;
                  state_nxt = loop_q ? S_FETCH : S_DONE;
               end else state_nxt = S_FETCH;
            end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q     <= '0;
         len_q      <= '0;
         loop_q     <= 1'b0;
         offset     <= '0;
         sent_cnt   <= '0;
         tx_data    <= '0;
         lat_cnt    <= '0;
         gap_cnt    <= '0;
         abort_pend <= 1'b0;
      end else begin
         lat_cnt <= (state == S_WAIT_DATA) ? lat_cnt + 2'd1 : 2'd0;
         gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
         if (state == S_IDLE) abort_pend <= 1'b0;
         else if (abort && (state == S_WAIT_ACK || state == S_WAIT_TX)) abort_pend <= 1'b1;
         if (launch) begin
            base_q   <= cfg_base;
            len_q    <= cfg_len;
            loop_q   <= cfg_loop;
            offset   <= '0;
            sent_cnt <= '0;
         end
         if (capture) tx_data <= mem_data;
         if (byte_done) begin
            sent_cnt <= sent_inc;
            offset   <= offset + ADDR_W'(1);
         end
         if (wrap) begin
            offset   <= '0;
            sent_cnt <= '0;
         end
      end
   end

   assign mem_addr  = base_q + offset;
   assign mem_rd_en = (state == S_FETCH);
   assign tx_start  = (state == S_LAUNCH);
   assign done      = (state == S_DONE);
   assign busy      = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_mem_stream_tx.sv
// Bench for mem_stream_tx: RAM and UART models, byte/address scoreboard,
// table-driven streams and hand-written corner sequences.
module tb_mem_stream_tx;

   localparam int ADDR_W  = 4;
   localparam int DATA_W  = 8;
   localparam int RD_LAT  = 3;
   localparam int GAP_CYC = 2;
   localparam int DEPTH   = 16;

   logic              clk, rst, start, abort, cfg_loop;
   logic [ADDR_W-1:0] cfg_base, mem_addr;
   logic [ADDR_W:0]   cfg_len, sent_cnt;
   logic              mem_rd_en, tx_start, tx_ready, busy, done;
   logic [DATA_W-1:0] mem_data, tx_data;

   mem_stream_tx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .GAP_CYC(GAP_CYC)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_loop(cfg_loop),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
      .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
      .busy(busy), .done(done), .sent_cnt(sent_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: data appears RD_LAT edges after the read strobe, noise otherwise
   logic [DATA_W-1:0] ram [DEPTH];
   logic [DATA_W-1:0] pipe [RD_LAT];
   always @(posedge clk) begin
      pipe[0] <= mem_rd_en ? ram[mem_addr] : DATA_W'($urandom);
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_data = pipe[RD_LAT-1];

   // UART model: ready drops the cycle after tx_start and stays low 3..8 cycles
   logic ready_m, uart_hold;
   int   ucnt;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_m <= 1'b1;
         ucnt    <= 0;
      end else if (tx_start) begin
         ready_m <= 1'b0;
         ucnt    <= $urandom_range(3, 8);
      end else if (ucnt != 0) begin
         ucnt <= ucnt - 1;
         if (ucnt == 1) ready_m <= 1'b1;
      end
   end
   assign tx_ready = ready_m & ~uart_hold;

   // scoreboard
   int tests_run = 0;
   int fails     = 0;
   int n_start = 0, n_done = 0, n_rd = 0;
   logic prev_start = 1'b0;
   logic [DATA_W-1:0] exp_q[$];
   logic [ADDR_W-1:0] addr_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) prev_start = 1'b0;
      else begin
         if (tx_start) begin
            n_start++;
            check("tx_start_one_cycle", prev_start, 0);
            if (exp_q.size() == 0) begin
               tests_run++; fails++;
               $display("FAIL tx_data: unexpected byte 0x%0h, expected none", tx_data);
            end else check("tx_data", tx_data, exp_q.pop_front());
         end
         if (mem_rd_en) begin
            n_rd++;
            if (addr_q.size() == 0) begin
               tests_run++; fails++;
               $display("FAIL mem_addr: unexpected read at 0x%0h, expected none", mem_addr);
            end else check("mem_addr", mem_addr, addr_q.pop_front());
         end
         if (done) begin
            n_done++;
            check("busy_low_at_done", busy, 0);
         end
         prev_start = tx_start;
      end
   end

   // driver tasks
   task automatic push_exp(input int base, input int len, input int period);
      for (int i = 0; i < len; i++) begin
         int idx = (base + (i % period)) % DEPTH;
         exp_q.push_back(ram[idx]);
         addr_q.push_back(ADDR_W'(idx));
      end
   endtask

   task automatic launch(input int base, input int len, input logic lp);
      @(negedge clk);
      cfg_base = ADDR_W'(base);
      cfg_len  = (ADDR_W+1)'(len);
      cfg_loop = lp;
      start    = 1'b1;
   endtask

   task automatic wait_done(input string name);
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (done) break;
      end
      check(name, done, 1);
   endtask

   task automatic wait_ready(input logic val, input string name);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (tx_ready == val) break;
      end
      check(name, tx_ready, val);
   endtask

   task automatic wait_tx_start(input string name);
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (tx_start) break;
      end
      check(name, tx_start, 1);
   endtask

   typedef struct {
      int base;
      int len;
      int exp_sent;
      int exp_tx;
   } vec_t;
   vec_t vecs[6];

   initial begin
      int s0, d0, r0, k;
      for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'(8'h30 + i * 11);
      vecs[0] = '{0, 10, 10, 10};
      vecs[1] = '{14, 4, 4, 4};
      vecs[2] = '{0, 0, 0, 0};
      vecs[3] = '{3, 16, 16, 16};
      vecs[4] = '{9, 1, 1, 1};
      vecs[5] = '{7, 5, 5, 5};

      rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_loop = 1'b0;
      cfg_base = '0; cfg_len = '0; uart_hold = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_rd_en", mem_rd_en, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_sent_cnt", sent_cnt, 0);
      check("rst_mem_addr", mem_addr, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // table-driven single-pass streams
      foreach (vecs[v]) begin
         s0 = n_start; d0 = n_done; r0 = n_rd;
         push_exp(vecs[v].base, vecs[v].len, DEPTH);
         launch(vecs[v].base, vecs[v].len, 1'b0);
         wait_done("vec_done_seen");
         @(negedge clk); start = 1'b0;
         repeat (3) @(negedge clk);
         check("vec_sent_cnt", sent_cnt, vecs[v].exp_sent);
         check("vec_tx_count", n_start - s0, vecs[v].exp_tx);
         check("vec_rd_count", n_rd - r0, vecs[v].exp_tx);
         check("vec_done_count", n_done - d0, 1);
         check("vec_queue_empty", exp_q.size(), 0);
         check("vec_idle", busy, 0);
      end

      // start-to-tx_start latency and post-byte gap
      push_exp(2, 2, DEPTH);
      launch(2, 2, 1'b0);
      k = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (tx_start) begin k = i; break; end
      end
      check("start_to_tx_start", k, 3 + RD_LAT);
      wait_ready(1'b0, "gap_ready_low");
      wait_ready(1'b1, "gap_ready_high");
      k = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (mem_rd_en) begin k = i; break; end
      end
      check("ready_to_next_fetch", k, 1 + GAP_CYC);
      wait_done("gap_done_seen");
      @(negedge clk); start = 1'b0;

      // empty stream: done soon after the edge, no reads
      r0 = n_rd;
      launch(5, 0, 1'b0);
      k = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (done) begin k = i; break; end
      end
      check("empty_done_within_2", (k >= 1 && k <= 2), 1);
      @(negedge clk); start = 1'b0;
      check("empty_no_reads", n_rd - r0, 0);

      // loop mode, abort during the 7th byte
      s0 = n_start; d0 = n_done; r0 = n_rd;
      push_exp(14, 7, 3);
      launch(14, 3, 1'b1);
      for (int b = 0; b < 7; b++) wait_tx_start("loop_tx_start");
      wait_ready(1'b0, "loop_ready_low");
      @(negedge clk); abort = 1'b1;
      wait_ready(1'b1, "loop_ready_high");
      check("abort_busy_before_rise_seen", busy, 1);
      @(negedge clk);
      check("abort_idle_after_rise", busy, 0);
      abort = 1'b0; start = 1'b0;
      repeat (30) @(negedge clk);
      check("loop_tx_count", n_start - s0, 7);
      check("loop_rd_count", n_rd - r0, 7);
      check("loop_no_done", n_done - d0, 0);
      check("loop_sent_cnt", sent_cnt, 1);
      check("loop_queue_empty", exp_q.size(), 0);

      // start edge while busy ignored; held start does not relaunch
      s0 = n_start; d0 = n_done; r0 = n_rd;
      push_exp(1, 3, DEPTH);
      launch(1, 3, 1'b0);
      wait_tx_start("held_first_tx");
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1;
      wait_done("held_done_seen");
      repeat (20) @(negedge clk);
      check("held_tx_count", n_start - s0, 3);
      check("held_rd_count", n_rd - r0, 3);
      check("held_done_count", n_done - d0, 1);
      check("held_stays_idle", busy, 0);
      start = 1'b0;

      // abort and start edge together in IDLE: no launch
      r0 = n_rd;
      @(negedge clk); start = 1'b1; abort = 1'b1; cfg_len = 5'd4;
      repeat (5) @(negedge clk);
      check("abort_wins_idle", busy, 0);
      abort = 1'b0;
      repeat (5) @(negedge clk);
      check("abort_wins_no_edge", busy, 0);
      check("abort_wins_no_reads", n_rd - r0, 0);
      start = 1'b0;

      // transmitter not ready: byte held in WAIT_RDY
      s0 = n_start;
      uart_hold = 1'b1;
      push_exp(8, 1, DEPTH);
      launch(8, 1, 1'b0);
      repeat (15) @(negedge clk);
      check("hold_no_tx_start", n_start - s0, 0);
      check("hold_busy", busy, 1);
      uart_hold = 1'b0;
      wait_done("hold_done_seen");
      check("hold_tx_count", n_start - s0, 1);
      @(negedge clk); start = 1'b0;

      // async reset mid-byte, then a fresh stream
      d0 = n_done;
      push_exp(4, 6, DEPTH);
      launch(4, 6, 1'b0);
      wait_tx_start("rst_first_tx");
      wait_tx_start("rst_second_tx");
      wait_ready(1'b0, "rst_ready_low");
      #2 rst = 1'b1; start = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_tx_data", tx_data, 0);
      check("arst_sent_cnt", sent_cnt, 0);
      check("arst_mem_addr", mem_addr, 0);
      check("arst_tx_start", tx_start | mem_rd_en | done, 0);
      exp_q.delete(); addr_q.delete();
      @(negedge clk); rst = 1'b0;
      push_exp(4, 3, DEPTH);
      launch(4, 3, 1'b0);
      wait_done("fresh_done_seen");
      @(negedge clk); start = 1'b0;
      check("fresh_sent_cnt", sent_cnt, 3);
      check("fresh_done_count", n_done - d0, 1);
      check("fresh_queue_empty", exp_q.size(), 0);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #300000;
      tests_run++; fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
